// File: rtl/sy_pkg.sv
// Shared EXU types and sizing constants.
// Imported by the dispatch-side steering logic and its credit counters.
package sy_pkg;

  localparam int EXU_IQ_LEN = 4;
  localparam int EXU_NUM_IQ = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  rob_id;
  } exu_packet_t;

endpackage

// File: rtl/sy_ppl_exu_iq_crd.sv
// Free-slot credit counter for one EXU issue queue.
// Saturates at both ends and flags any overflow/underflow stickily.
module sy_ppl_exu_iq_crd #(
  parameter int DEPTH = 4,
  parameter int WTH   = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           inc_i,
  input  logic           dec_i,
  output logic [WTH-1:0] crd_o,
  output logic           err_o
);

  localparam logic [WTH-1:0] FULL = WTH'(DEPTH);

  logic [WTH-1:0] cnt_q;
  logic           err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else if (flush_i) begin
      cnt_q <= FULL;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == FULL) err_q <= 1'b1;
      else               cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_q <= 1'b1;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign crd_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/sy_ppl_exu_iq_steer.sv
// Steers one dispatch stream onto NUM_IQ issue queues by credit,
// least-occupied first with round-robin tie break, via one output register.
module sy_ppl_exu_iq_steer
  import sy_pkg::*;
#(
  parameter int NUM_IQ   = EXU_NUM_IQ,
  parameter int IQ_DEPTH = EXU_IQ_LEN,
  localparam int CRD_WTH = $clog2(IQ_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      dis_steer__vld_i,
  output logic                      steer_dis__rdy_o,
  input  exu_packet_t               dis_steer__packet_i,
  output logic [NUM_IQ-1:0]         iq_vld_o,
  input  logic [NUM_IQ-1:0]         iq_rdy_i,
  output exu_packet_t               iq_packet_o,
  input  logic [NUM_IQ-1:0]         iq_issue_i,
  output logic [NUM_IQ*CRD_WTH-1:0] crd_o,
  output logic                      err_o
);

  localparam int PW = (NUM_IQ > 1) ? $clog2(NUM_IQ) : 1;

  logic [NUM_IQ-1:0][CRD_WTH-1:0] crd;
  logic [NUM_IQ-1:0]              err_v;

  logic              vld_q;
  logic [NUM_IQ-1:0] tgt_q;
  exu_packet_t       packet_q;
  logic [PW-1:0]     rr_q;

  logic [PW-1:0]      sel;
  logic [PW-1:0]      rr_next;
  logic [NUM_IQ-1:0]  sel_oh;
  logic [CRD_WTH-1:0] best;
  logic               any_crd;
  logic               out_fire;
  logic               cap;

  // Scan from rr_q circularly; strict '>' keeps the first tied queue.
  always_comb begin
    int idx;
    idx  = 0;
    sel  = '0;
    best = '0;
    for (int i = 0; i < NUM_IQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_IQ) idx = idx - NUM_IQ;
      if (crd[idx] > best) begin
        best = crd[idx];
        sel  = PW'(idx);
      end
    end
    any_crd = (best != '0);
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    rr_next = (sel == PW'(NUM_IQ - 1)) ? '0 : sel + 1'b1;
  end

  assign iq_vld_o    = vld_q ? tgt_q : '0;
  assign iq_packet_o = packet_q;
  assign out_fire    = |(iq_vld_o & iq_rdy_i);

  assign steer_dis__rdy_o = !flush_i && (!vld_q || out_fire) && any_crd;
  assign cap = dis_steer__vld_i && steer_dis__rdy_o;

  for (genvar k = 0; k < NUM_IQ; k++) begin : g_crd
    sy_ppl_exu_iq_crd #(
      .DEPTH(IQ_DEPTH),
      .WTH  (CRD_WTH)
    ) u_crd (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(flush_i),
      .inc_i  (iq_issue_i[k]),
      .dec_i  (cap && sel_oh[k]),
      .crd_o  (crd[k]),
      .err_o  (err_v[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= 1'b0;
      tgt_q    <= '0;
      packet_q <= '0;
      rr_q     <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (cap) begin
      vld_q    <= 1'b1;
      tgt_q    <= sel_oh;
      packet_q <= dis_steer__packet_i;
      rr_q     <= rr_next;
    end else if (out_fire) begin
      vld_q <= 1'b0;
    end
  end

  assign crd_o = crd;
  assign err_o = |err_v;

endmodule

// File: tb/tb_sy_ppl_exu_iq_steer.sv
// Directed bench for the IQ steering stage (2 queues, depth 4).
// Expected targets and credits are hand-computed per vector.
module tb_sy_ppl_exu_iq_steer;
  import sy_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dvld;
  logic        drdy;
  exu_packet_t dpkt;
  logic [1:0]  ivld;
  logic [1:0]  irdy;
  exu_packet_t opkt;
  logic [1:0]  iss;
  logic [5:0]  crd;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sy_ppl_exu_iq_steer #(
    .NUM_IQ  (2),
    .IQ_DEPTH(4)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .dis_steer__vld_i   (dvld),
    .steer_dis__rdy_o   (drdy),
    .dis_steer__packet_i(dpkt),
    .iq_vld_o           (ivld),
    .iq_rdy_i           (irdy),
    .iq_packet_o        (opkt),
    .iq_issue_i         (iss),
    .crd_o              (crd),
    .err_o              (err)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exu_packet_t mkp(input int n);
    exu_packet_t p;
    p        = '0;
    p.pc     = 32'h1000 + 32'(n) * 4;
    p.instr  = 32'hA000_0000 | 32'(n);
    p.rob_id = 6'(n);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    dvld  = 1'b0;
    dpkt  = '0;
    irdy  = 2'b11;
    iss   = 2'b00;
    tick();
    tick();
    check("rst_vld", ivld, 2'b00);
    check("rst_crd", crd, {3'd4, 3'd4});
    check("rst_err", err, 1'b0);
    check("rst_pkt", opkt, '0);
    rst = 1'b0;
    #1;
    check("rst_rdy", drdy, 1'b1);

    // alternate q0,q1,q0,q1 from equal credits
    for (int i = 0; i < 4; i++) begin
      dvld = 1'b1;
      dpkt = mkp(i);
      tick();
      check("b2b_tgt", ivld, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("b2b_pkt", opkt, mkp(i));
    end
    dvld = 1'b0;
    check("b2b_crd", crd, {3'd2, 3'd2});
    tick();
    check("b2b_idle", ivld, 2'b00);

    // drain all credits
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_crd", crd, {3'd4, 3'd4});
    for (int i = 0; i < 8; i++) begin
      dvld = 1'b1;
      dpkt = mkp(10 + i);
      tick();
      check("fill_tgt", ivld, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    dpkt = mkp(18);
    check("empty_crd", crd, 6'd0);
    check("empty_rdy", drdy, 1'b0);
    tick();
    check("empty_vld", ivld, 2'b00);
    iss = 2'b10;
    tick();
    iss = 2'b00;
    check("ret_crd", crd, {3'd1, 3'd0});
    check("ret_rdy", drdy, 1'b1);
    tick();
    check("ret_tgt", ivld, 2'b10);
    check("ret_pkt", opkt, mkp(18));
    dvld = 1'b0;

    // max credit beats round robin
    iss = 2'b11;
    tick();
    iss = 2'b10;
    tick();
    tick();
    iss = 2'b00;
    check("max_crd0", crd, {3'd3, 3'd1});
    dvld = 1'b1;
    dpkt = mkp(20);
    tick();
    check("max_tgt", ivld, 2'b10);
    check("max_crd1", crd, {3'd2, 3'd1});

    // stall on q0
    dpkt = mkp(21);
    tick();
    check("st_a_tgt", ivld, 2'b10);
    irdy = 2'b10;
    dpkt = mkp(22);
    tick();
    check("st_b_tgt", ivld, 2'b01);
    check("st_b_crd", crd, {3'd1, 3'd0});
    dpkt = mkp(23);
    for (int i = 0; i < 3; i++) begin
      check("st_vld", ivld, 2'b01);
      check("st_pkt", opkt, mkp(22));
      check("st_rdy", drdy, 1'b0);
      tick();
    end
    irdy = 2'b11;
    #1;
    check("rel_rdy", drdy, 1'b1);
    tick();
    check("rel_tgt", ivld, 2'b10);
    check("rel_pkt", opkt, mkp(23));
    check("rel_crd", crd, {3'd0, 3'd0});
    dvld = 1'b0;

    // cap and issue on q0 together
    iss = 2'b01;
    tick();
    check("same_pre", crd, {3'd0, 3'd1});
    dvld = 1'b1;
    dpkt = mkp(24);
    tick();
    check("same_tgt", ivld, 2'b01);
    check("same_crd", crd, {3'd0, 3'd1});
    dvld = 1'b0;
    iss  = 2'b10;
    tick();
    tick();
    check("pre_fl_crd", crd, {3'd2, 3'd1});
    dvld = 1'b1;
    dpkt = mkp(25);
    tick();
    check("pre_fl_tgt", ivld, 2'b10);
    check("pre_fl_crd2", crd, {3'd2, 3'd1});

    // flush with a held packet, issues ignored
    dvld  = 1'b1;
    dpkt  = mkp(26);
    irdy  = 2'b00;
    iss   = 2'b11;
    flush = 1'b1;
    #1;
    check("fl_rdy", drdy, 1'b0);
    check("fl_vld", ivld, 2'b10);
    tick();
    flush = 1'b0;
    dvld  = 1'b0;
    iss   = 2'b00;
    irdy  = 2'b11;
    check("fl_vld_nx", ivld, 2'b00);
    check("fl_crd_nx", crd, {3'd4, 3'd4});
    check("fl_err", err, 1'b0);

    // overflow sets sticky err
    iss = 2'b01;
    tick();
    iss = 2'b00;
    check("ovf_crd", crd, {3'd4, 3'd4});
    check("ovf_err", err, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("ovf_err_fl", err, 1'b1);
    check("ovf_crd_fl", crd, {3'd4, 3'd4});
    check("ovf_rdy", drdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sy_ppl_exu_iq_steer.md
Name: sy_ppl_exu_iq_steer

Overview:
Dispatch-side scheduler that shares one dispatch packet stream between NUM_IQ identical EXU issue queues. It sits between dispatch and the per-pipe issue queues. Per queue, it tracks free-slot credits, reserved at dispatch and returned on issue. Each packet is steered to the least-occupied queue, with round-robin on ties, through a one-entry registered output stage.

Parameters:
NUM_IQ, 2, number of target issue queues (2..4)
IQ_DEPTH, EXU_IQ_LEN, entries per target queue; credit reset value
CRD_WTH, $clog2(IQ_DEPTH+1), credit counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  pipeline flush
dis_steer__vld_i  in  1  dispatch packet valid
steer_dis__rdy_o  out  1  steer stage can accept
dis_steer__packet_i  in  exu_packet_t  dispatch packet
iq_vld_o  out  NUM_IQ  one-hot valid towards queue k
iq_rdy_i  in  NUM_IQ  queue k ready (exu_dis__rdy_o of queue k)
iq_packet_o  out  exu_packet_t  packet shared by all queues, qualified by iq_vld_o
iq_issue_i  in  NUM_IQ  queue k issued one entry this cycle (its vld & rdy)
crd_o  out  NUM_IQ*CRD_WTH  per-queue free credits (debug/perf)
err_o  out  1  sticky credit overflow/underflow flag

Behaviour:
- Reset values: vld_q=0, so iq_vld_o=0. Every credit is IQ_DEPTH. rr_ptr=0. err_o=0. packet_q=0. steer_dis__rdy_o=1 once reset is released.
- Output stage state: vld_q, tgt_q (one-hot, NUM_IQ), packet_q.
  - iq_vld_o = vld_q ? tgt_q : 0.
  - iq_packet_o = packet_q.
- out_fire = |(iq_vld_o & iq_rdy_i). The held packet leaves only when its target queue is ready.
- steer_dis__rdy_o = !flush_i && (!vld_q || out_fire) && any_crd, where any_crd = (at least one queue has credit>0).
- cap = dis_steer__vld_i && steer_dis__rdy_o.
- Latency: a packet accepted in cycle N is presented to its queue in cycle N+1. Back-to-back throughput is 1 packet/cycle while the target is ready.
- Target selection is combinational in the cap cycle, using current credits:
  - Eligible queues are those with credit>0.
  - Choose the eligible queue with the maximum credit.
  - On a tie, choose the first tied queue at or after rr_ptr, circularly.
  - On cap, rr_ptr <= (chosen+1) mod NUM_IQ. Otherwise rr_ptr is unchanged.
- Credit update per queue k:
  - dec = cap && chosen==k.
  - inc = iq_issue_i[k].
  - dec&&inc: unchanged. dec only: -1. inc only: +1.
- Credit boundaries:
  - An increment at IQ_DEPTH saturates (no change) and sets err_o.
  - A decrement at 0 cannot occur by construction. If it does occur, hold at 0 and set err_o.
- Reservation happens at capture, so a credit is consumed while the packet is still in the output stage. Consequently the target's iq_rdy_i is normally 1. iq_rdy_i=0 (e.g. after a queue-side stall) holds vld_q/tgt_q/packet_q stable until ready. Packet and target never change while vld_q=1 and out_fire=0.
- Flush has the highest priority:
  - Next cycle: vld_q=0, all credits=IQ_DEPTH, rr_ptr unchanged.
  - The queues flush concurrently, so iq_issue_i in the flush cycle is ignored.
  - No capture in the flush cycle (rdy forced 0).
  - A packet held at flush is dropped; iq_vld_o is still driven in the flush cycle, but the queues ignore inserts while flushing.
- err_o: sticky until reset. Flush does not clear it.
- Simultaneous out_fire and cap: the stage reloads in the same cycle (no bubble).
- No combinational path from iq_issue_i to any output other than through registers. steer_dis__rdy_o depends combinationally on iq_rdy_i and flush_i only.

Decomposition:
- sy_pkg: add constant EXU_NUM_IQ. exu_packet_t is reused unchanged.
- One sub-module is natural: sy_ppl_exu_iq_crd, a single-queue credit counter (inc, dec, flush, count, err). It is instantiated NUM_IQ times.
- Max-credit/round-robin selection and the output stage stay in the top module.

Test Plan:
- Reset, then 4 back-to-back packets with NUM_IQ=2, IQ_DEPTH=4 and no issues.
  - Targets alternate q0,q1,q0,q1, each 1 cycle after capture.
  - End credits: 2,2.
- No issues, 8 packets.
  - After 8 captures both credits are 0 and steer_dis__rdy_o=0.
  - Pulse iq_issue_i[1]: next cycle credit1=1, rdy=1, and the next packet goes to q1.
- Credits q0=1, q1=3 (via prior traffic).
  - The next packet goes to q1 (max credit) regardless of rr_ptr.
- Hold iq_rdy_i[0]=0 while a packet targets q0.
  - iq_vld_o=01 with the packet stable for 3 cycles and steer_dis__rdy_o=0.
  - Release: fire, and a new capture occurs in the same cycle.
- Same-cycle events on q0: cap to q0 and iq_issue_i[0]=1 → credit0 unchanged.
  - Flush while vld_q=1 and credits at 1,2: next cycle iq_vld_o=0, credits 4,4, err_o=0.
- Inject iq_issue_i[0] while credit0=4 → credit0 stays 4 and err_o=1, remaining 1 after a later flush.
